// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and FSM state type shared by the operand controller.
package alu_pkg;

    localparam logic [3:0] ADD  = 4'd0;
    localparam logic [3:0] SUB  = 4'd1;
    localparam logic [3:0] SHL  = 4'd2;
    localparam logic [3:0] SHR  = 4'd3;
    localparam logic [3:0] CMP  = 4'd4;
    localparam logic [3:0] AND  = 4'd5;
    localparam logic [3:0] OR   = 4'd6;
    localparam logic [3:0] XOR  = 4'd7;
    localparam logic [3:0] NAND = 4'd8;
    localparam logic [3:0] NOR  = 4'd9;
    localparam logic [3:0] XNOR = 4'd10;
    localparam logic [3:0] INV  = 4'd11;
    localparam logic [3:0] NEG  = 4'd12;
    localparam logic [3:0] STO  = 4'd13;
    localparam logic [3:0] SWP  = 4'd14;
    localparam logic [3:0] LOAD = 4'd15;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, optional counter filter and rising-edge pulse.
// The counter filter is built only when ALU_OPERAND_CTRL_DEBOUNCE_EN is defined.
module btn_debounce
    import alu_pkg::*;
#(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    if (DB_CYCLES < 1) begin : g_bad_db
        $error("DB_CYCLES must be at least 1");
    end

    logic [1:0] sync;
    logic       level;
    logic       level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= 2'b00;
            level_q <= 1'b0;
        end else begin
            sync    <= {sync[0], btn};
            level_q <= level;
        end
    end

`ifdef ALU_OPERAND_CTRL_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [CW-1:0] cnt;

    // level flips only after DB_CYCLES consecutive samples that disagree with it
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync[1] == level) begin
            cnt <= '0;
        end else if (cnt == CW'(DB_CYCLES - 1)) begin
            cnt   <= '0;
            level <= sync[1];
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign level = sync[1];
`endif

    assign rise = level & ~level_q;

endmodule

// File: rtl/alu_operand_ctrl.sv
// alu_operand_ctrl: button-driven IDLE/EXEC/WB sequencer owning ALU operand registers A and B.
// Define ALU_OPERAND_CTRL_DEBOUNCE_EN to enable the DB_CYCLES debounce filter on btnC.
module alu_operand_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             btnU,
    input  logic             btnC,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [3:0]       op_sel,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             op_done
);

    logic             go;
    logic [WIDTH-1:0] din_q;
    state_t           state;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btnc (
        .clk  (clk),
        .rst  (btnU),
        .btn  (btnC),
        .rise (go)
    );

    // edges arriving outside IDLE are dropped, never queued
    always_ff @(posedge clk) begin
        if (btnU) begin
            state   <= IDLE;
            a       <= '0;
            b       <= '0;
            result  <= '0;
            din_q   <= '0;
            op_sel  <= 4'd0;
            busy    <= 1'b0;
            op_done <= 1'b0;
        end else begin
            op_done <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    op_sel <= sel;
                    din_q  <= din;
                    busy   <= 1'b1;
                    state  <= EXEC;
                end
                EXEC: begin
                    result <= y;
                    state  <= WB;
                end
                WB: begin
                    a       <= op_sel == STO ? din_q : op_sel == SWP ? b : op_sel == LOAD ? a : result;
                    b       <= op_sel == LOAD ? din_q : op_sel == SWP ? a : b;
                    busy    <= 1'b0;
                    op_done <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
